// File: rtl/frame_capture.sv
// frame_capture: on-chip sink for the filtered pixel stream.
// Optional `FRAME_CAPTURE_BINARIZE_EN` thresholds the readout data.
module frame_capture #(
   parameter int         IMAGE_WIDTH  = 320,
   parameter int         IMAGE_HEIGHT = 240,
   parameter int         IMAGE_SIZE   = IMAGE_WIDTH*IMAGE_HEIGHT,
   parameter int         ADDR_W       = 17,
   parameter int         IDLE_TIMEOUT = IMAGE_WIDTH*3,
   parameter logic [7:0] THRESHOLD    = 8'd128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        pixel_in,
   input  logic              valid_in,
   output logic              frame_done,
   output logic              short_frame,
   output logic [ADDR_W-1:0] capture_count,
   output logic              overflow,
   input  logic              rd_start,
   output logic [7:0]        rd_pixel,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              rd_last
);

   localparam logic [1:0] CAPTURE = 2'd0;
   localparam logic [1:0] FULL    = 2'd1;
   localparam logic [1:0] READOUT = 2'd2;

   localparam int MEM_AW = $clog2(IMAGE_SIZE);
   localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_SIZE - 1);

   logic [1:0]        state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [IDLE_W-1:0] idle_cnt;
   logic              short_q;
   logic              ovf_q;

   logic [7:0]        mem [IMAGE_SIZE];
   logic [7:0]        mem_q;
   logic              m_v;
   logic              m_last;

   // two-entry output queue: o_* is presented, s_* is the skid slot
   logic              o_v, s_v;
   logic [7:0]        o_d, s_d;
   logic              o_last, s_last;

   logic              wr_en;
   logic              pop;
   logic              issue;
   logic              last_xfer;
   logic [2:0]        occ;
   logic [MEM_AW-1:0] wr_addr;
   logic [MEM_AW-1:0] rd_addr;

   assign wr_en     = (state == CAPTURE) && valid_in;
   assign pop       = o_v && rd_ready;
   assign last_xfer = pop && o_last;
   assign occ       = {2'b0, o_v} + {2'b0, s_v} + {2'b0, m_v} - {2'b0, pop};
   // only launch a read if its result is guaranteed a queue slot
   assign issue     = (state == READOUT) && (rd_ptr < wr_ptr) && (occ <= 3'd1);
   assign wr_addr   = wr_ptr[MEM_AW-1:0];
   assign rd_addr   = rd_ptr[MEM_AW-1:0];

   // frame buffer write port
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= pixel_in;
   end

   // frame buffer registered read port
   always_ff @(posedge clk) begin
      if (issue) mem_q <= mem[rd_addr];
   end

   // capture / full / readout sequencing
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= CAPTURE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         idle_cnt <= '0;
         short_q  <= 1'b0;
      end else begin
         case (state)
            CAPTURE: begin
               if (valid_in) begin
                  wr_ptr   <= wr_ptr + ADDR_W'(1);
                  idle_cnt <= '0;
                  if (wr_ptr == LAST_ADDR) state <= FULL;
               end else if (wr_ptr != '0) begin
                  if (idle_cnt == IDLE_MAX) begin
                     state   <= FULL;
                     short_q <= 1'b1;
                  end else begin
                     idle_cnt <= idle_cnt + IDLE_W'(1);
                  end
               end
            end
            FULL: begin
               if (rd_start) begin
                  state  <= READOUT;
                  rd_ptr <= '0;
               end
            end
            READOUT: begin
               if (issue) rd_ptr <= rd_ptr + ADDR_W'(1);
               if (last_xfer) begin
                  state    <= CAPTURE;
                  wr_ptr   <= '0;
                  idle_cnt <= '0;
                  short_q  <= 1'b0;
               end
            end
            default: state <= CAPTURE;
         endcase
      end
   end

   // sticky flag for pixels arriving while the buffer is closed
   always_ff @(posedge clk) begin
      if (!rst) ovf_q <= 1'b0;
      else if (valid_in && (state != CAPTURE)) ovf_q <= 1'b1;
   end

   // tracks the read in flight through the BRAM
   always_ff @(posedge clk) begin
      if (!rst) begin
         m_v    <= 1'b0;
         m_last <= 1'b0;
      end else begin
         m_v    <= issue;
         m_last <= issue && (rd_ptr == wr_ptr - ADDR_W'(1));
      end
   end

   // output queue absorbing the read latency under back-pressure
   always_ff @(posedge clk) begin
      if (!rst) begin
         o_v    <= 1'b0;
         o_d    <= 8'h00;
         o_last <= 1'b0;
         s_v    <= 1'b0;
         s_d    <= 8'h00;
         s_last <= 1'b0;
      end else if (pop) begin
         if (s_v) begin
            o_d    <= s_d;
            o_last <= s_last;
            s_v    <= m_v;
            s_d    <= mem_q;
            s_last <= m_last;
         end else begin
            o_v    <= m_v;
            o_d    <= m_v ? mem_q : o_d;
            o_last <= m_v && m_last;
         end
      end else if (m_v) begin
         if (!o_v) begin
            o_v    <= 1'b1;
            o_d    <= mem_q;
            o_last <= m_last;
         end else if (!s_v) begin
            s_v    <= 1'b1;
            s_d    <= mem_q;
            s_last <= m_last;
         end
      end
   end

`ifdef FRAME_CAPTURE_BINARIZE_EN
   assign rd_pixel = (o_d >= THRESHOLD) ? 8'hFF : 8'h00;
`else
   logic unused_thr;
   assign unused_thr = ^THRESHOLD;
   assign rd_pixel   = o_d;
`endif

   assign rd_valid      = o_v;
   assign rd_last       = o_v && o_last;
   assign frame_done    = (state == FULL) || (state == READOUT);
   assign short_frame   = short_q;
   assign capture_count = wr_ptr;
   assign overflow      = ovf_q;

endmodule

// File: tb/tb_frame_capture.sv
// tb_frame_capture: directed checks of capture, timeout, overflow,
// back-pressured readout and reset, on a reduced 40x10 frame.
module tb_frame_capture;

   localparam int W    = 40;
   localparam int H    = 10;
   localparam int SIZE = W*H;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  pixel_in = 8'h00;
   logic        valid_in = 1'b0;
   logic        frame_done;
   logic        short_frame;
   logic [16:0] capture_count;
   logic        overflow;
   logic        rd_start = 1'b0;
   logic [7:0]  rd_pixel;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic        rd_last;

   int tests  = 0;
   int failed = 0;
   int sent   = 0;
   int cyc    = 0;

   typedef struct {
      logic rst; logic vin; logic ramp; logic rs; logic rr;
      logic [7:0] pix; int n;
      logic fd; logic sf; logic ov; logic rv; logic rl;
      logic [16:0] cc; logic [7:0] rp;
   } vec_t;

   vec_t tv [10];

   frame_capture #(
      .IMAGE_WIDTH (W),
      .IMAGE_HEIGHT(H)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pixel_in     (pixel_in),
      .valid_in     (valid_in),
      .frame_done   (frame_done),
      .short_frame  (short_frame),
      .capture_count(capture_count),
      .overflow     (overflow),
      .rd_start     (rd_start),
      .rd_pixel     (rd_pixel),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_last      (rd_last)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_pix(input int v);
      logic [7:0] r;
      r = v[7:0];
`ifdef FRAME_CAPTURE_BINARIZE_EN
      r = (r >= 8'd128) ? 8'hFF : 8'h00;
`endif
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic capture(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         valid_in = 1'b1;
         pixel_in = 8'(base + i);
         step();
      end
      valid_in = 1'b0;
   endtask

   task automatic start_rd();
      rd_start = 1'b1;
      step();
      chk("start_n0_valid", rd_valid, 0);
      rd_start = 1'b0;
      step();
      chk("start_n1_valid", rd_valid, 0);
      step();
      chk("start_n2_valid", rd_valid, 1);
   endtask

   task automatic drain(input int count, input int base, input bit toggle,
                        input bit vin, input int stop_after,
                        output int used);
      int k;
      logic hv, hl;
      logic [7:0] hp;
      k = 0; used = 0; hv = 1'b0; hl = 1'b0; hp = 8'h00;
      valid_in = vin;
      pixel_in = 8'hEE;
      while (k < stop_after && used < 20*count + 50) begin
         rd_ready = toggle ? (used % 4 == 0 || used % 4 == 3) : 1'b1;
         if (hv) begin
            chk("stall_valid", rd_valid, 1);
            chk("stall_pixel", rd_pixel, hp);
            chk("stall_last", rd_last, hl);
         end
         if (rd_valid && rd_ready) begin
            chk($sformatf("rd_pixel[%0d]", k), rd_pixel, exp_pix(base + k));
            chk($sformatf("rd_last[%0d]", k), rd_last, k == count - 1);
            k++;
            hv = 1'b0;
         end else begin
            hv = rd_valid;
            hp = rd_pixel;
            hl = rd_last;
         end
         step();
         used++;
      end
      if (k < stop_after) begin
         failed++;
         tests++;
         $display("FAIL drain_timeout: got %0d transfers expected %0d",
                  k, stop_after);
      end
      rd_ready = 1'b0;
      valid_in = 1'b0;
   endtask

   task automatic post_frame(input logic ov);
      chk("post_valid", rd_valid, 0);
      chk("post_frame_done", frame_done, 0);
      chk("post_short", short_frame, 0);
      chk("post_count", capture_count, 0);
      chk("post_overflow", overflow, ov);
   endtask

   initial begin
      tv[0] = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,2,
                1'b0,1'b0,1'b0,1'b0,1'b0,17'd0,8'd0};
      tv[1] = '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00,200,
                1'b0,1'b0,1'b0,1'b0,1'b0,17'd0,8'd0};
      tv[2] = '{1'b1,1'b1,1'b1,1'b0,1'b0,8'h00,150,
                1'b0,1'b0,1'b0,1'b0,1'b0,17'd150,8'd0};
      tv[3] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,120,
                1'b0,1'b0,1'b0,1'b0,1'b0,17'd150,8'd0};
      tv[4] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1,
                1'b1,1'b1,1'b0,1'b0,1'b0,17'd150,8'd0};
      tv[5] = '{1'b1,1'b1,1'b0,1'b0,1'b0,8'hEE,3,
                1'b1,1'b1,1'b1,1'b0,1'b0,17'd150,8'd0};
      tv[6] = '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00,1,
                1'b1,1'b1,1'b1,1'b0,1'b0,17'd150,8'd0};
      tv[7] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1,
                1'b1,1'b1,1'b1,1'b0,1'b0,17'd150,8'd0};
      tv[8] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,1,
                1'b1,1'b1,1'b1,1'b1,1'b0,17'd150,8'd100};
      tv[9] = '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00,5,
                1'b1,1'b1,1'b1,1'b1,1'b0,17'd150,8'd100};

      // reset, empty frame, short frame by timeout, overflow, readout start
      for (int v = 0; v < 10; v++) begin
         for (int r = 0; r < tv[v].n; r++) begin
            rst      = tv[v].rst;
            valid_in = tv[v].vin;
            pixel_in = tv[v].ramp ? 8'(100 + sent) : tv[v].pix;
            rd_start = tv[v].rs;
            rd_ready = tv[v].rr;
            step();
            if (tv[v].ramp && tv[v].vin) sent++;
         end
         chk($sformatf("v%0d.frame_done", v), frame_done, tv[v].fd);
         chk($sformatf("v%0d.short", v), short_frame, tv[v].sf);
         chk($sformatf("v%0d.overflow", v), overflow, tv[v].ov);
         chk($sformatf("v%0d.rd_valid", v), rd_valid, tv[v].rv);
         chk($sformatf("v%0d.rd_last", v), rd_last, tv[v].rl);
         chk($sformatf("v%0d.count", v), capture_count, tv[v].cc);
         chk($sformatf("v%0d.rd_pixel", v), rd_pixel,
             exp_pix(int'(tv[v].rp)));
      end
      rd_start = 1'b0;
      valid_in = 1'b0;

      // drain the short frame with back-pressure and pixels arriving
      drain(150, 100, 1'b1, 1'b1, 150, cyc);
      post_frame(1'b1);
      valid_in = 1'b1;
      pixel_in = 8'h33;
      step();
      valid_in = 1'b0;
      chk("rewrite_count", capture_count, 1);
      chk("overflow_sticky", overflow, 1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("overflow_reset", overflow, 0);
      chk("count_reset", capture_count, 0);

      // full frame, readout with ready pattern 1,0,0,1
      capture(SIZE - 1, 0);
      chk("full_m1_done", frame_done, 0);
      chk("full_m1_count", capture_count, SIZE - 1);
      capture(1, SIZE - 1);
      chk("full_done", frame_done, 1);
      chk("full_short", short_frame, 0);
      chk("full_count", capture_count, SIZE);
      start_rd();
      chk("full_first_pixel", rd_pixel, exp_pix(0));
      drain(SIZE, 0, 1'b1, 1'b0, SIZE, cyc);
      post_frame(1'b0);

      // reset during readout, then a fresh frame at full throughput
      capture(SIZE, 0);
      start_rd();
      drain(SIZE, 0, 1'b0, 1'b0, 100, cyc);
      rst = 1'b0;
      step();
      chk("mid_rst_done", frame_done, 0);
      chk("mid_rst_short", short_frame, 0);
      chk("mid_rst_count", capture_count, 0);
      chk("mid_rst_ovf", overflow, 0);
      chk("mid_rst_valid", rd_valid, 0);
      chk("mid_rst_last", rd_last, 0);
      chk("mid_rst_pixel", rd_pixel, 0);
      rst = 1'b1;
      capture(SIZE, 7);
      chk("fresh_count", capture_count, SIZE);
      chk("fresh_done", frame_done, 1);
      start_rd();
      drain(SIZE, 7, 1'b0, 1'b0, SIZE, cyc);
      chk("fresh_cycles", cyc, SIZE);
      post_frame(1'b0);

`ifdef FRAME_CAPTURE_BINARIZE_EN
      begin
         logic [7:0] bv [3];
         logic [7:0] be [3];
         bv[0] = 8'd127; bv[1] = 8'd128; bv[2] = 8'd255;
         be[0] = 8'h00;  be[1] = 8'hFF;  be[2] = 8'hFF;
         for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            pixel_in = bv[i];
            step();
         end
         valid_in = 1'b0;
         for (int i = 0; i < W*3 + 1; i++) step();
         chk("bin_done", frame_done, 1);
         chk("bin_short", short_frame, 1);
         chk("bin_count", capture_count, 3);
         start_rd();
         rd_ready = 1'b1;
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("bin_pixel[%0d]", i), rd_pixel, be[i]);
            chk($sformatf("bin_last[%0d]", i), rd_last, i == 2);
            step();
         end
         rd_ready = 1'b0;
         post_frame(1'b0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/frame_capture.md
# frame_capture

Sink end of the filtered pixel stream. It accepts the `pixel_out`/`valid_out` stream produced by `image_filter_top`, stores one frame in an internal buffer, and closes the frame on a full count or an idle timeout. It then streams the frame back out over a ready/valid readout port to a host, UART or DMA bridge. This replaces testbench-side output capture with synthesizable on-chip capture.

## Interface
- `IMAGE_WIDTH`, 320: pixels per line; used only to derive defaults.
- `IMAGE_HEIGHT`, 240: lines per frame.
- `IMAGE_SIZE`, `IMAGE_WIDTH*IMAGE_HEIGHT`: buffer depth in pixels.
- `ADDR_W`, 17: pointer/count width; must satisfy 2^ADDR_W > `IMAGE_SIZE`.
- `IDLE_TIMEOUT`, `IMAGE_WIDTH*3`: idle cycles that close a partial frame.
- `THRESHOLD`, 8'd128: binarize threshold; used only when `FRAME_CAPTURE_BINARIZE_EN` is defined.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `pixel_in`  in  8  filtered pixel, from `image_filter_top.pixel_out`.
- `valid_in`  in  1  pixel qualifier, from `image_filter_top.valid_out`.
- `frame_done`  out  1  high while a closed frame awaits or is being read out.
- `short_frame`  out  1  frame was closed by timeout rather than by full count.
- `capture_count`  out  ADDR_W  pixels stored in the current frame.
- `overflow`  out  1  sticky; a pixel arrived while the buffer was not accepting.
- `rd_start`  in  1  request readout; honored only in FULL.
- `rd_pixel`  out  8  readout data.
- `rd_valid`  out  1  readout data valid.
- `rd_ready`  in  1  downstream accepts `rd_pixel`.
- `rd_last`  out  1  qualifies the final readout pixel.

## Operation
- States are CAPTURE, FULL and READOUT. Reset enters CAPTURE.
- **CAPTURE**
  - Each cycle with `valid_in`=1 writes `pixel_in` to `mem[wr_ptr]` and increments `wr_ptr`. `capture_count` equals `wr_ptr`.
  - When the write at `wr_ptr`=`IMAGE_SIZE-1` occurs, the next state is FULL. `short_frame` is 0.
  - An idle counter clears on every `valid_in` and counts otherwise. It runs only while `wr_ptr`>0.
  - When the idle counter reaches `IDLE_TIMEOUT`, the next state is FULL with `short_frame`=1. `capture_count` keeps the partial count.
  - With `wr_ptr`=0 the idle counter never runs, so an empty frame never closes.
- **FULL**
  - `frame_done`=1.
  - `valid_in`=1 drops the pixel and sets `overflow`.
  - `rd_start`=1 moves to READOUT and clears `rd_ptr`.
- **READOUT**
  - Emits `mem[0..capture_count-1]` in order.
  - A transfer occurs on a cycle where `rd_valid`&&`rd_ready`.
  - `rd_last`=1 together with `rd_valid` on the pixel at index `capture_count-1`.
  - After the last transfer, the next state is CAPTURE. `wr_ptr`, `capture_count`, `frame_done` and `short_frame` clear.
  - Incoming `valid_in` is dropped and sets `overflow`.
- `rd_start` in CAPTURE or READOUT is ignored.
- `overflow` clears only on reset.
- The buffer is a single-port-write, single-port-read inferred BRAM of `IMAGE_SIZE`x8 with a 1-cycle registered read.
- Reset mid-operation discards buffered data. No memory clear is performed.

## Timing
- **Reset values:** `frame_done`, `short_frame`, `overflow`, `rd_valid` and `rd_last` are 0. `capture_count` and `rd_pixel` are 0.
- **Write latency:** a pixel sampled with `valid_in` at edge N is counted in `capture_count` after edge N.
- `frame_done` rises one cycle after the closing write or the timeout cycle.
- **Readout start:** `rd_start` sampled at edge N gives first `rd_valid`=1 after edge N+2, one cycle for the state change and one for the BRAM read.
- **Throughput:** one pixel per cycle while `rd_ready`=1. A prefetch/skid register absorbs the read latency.
- **Back-pressure:** while `rd_valid`&&!`rd_ready`, `rd_pixel` and `rd_last` hold stable and `rd_ptr` does not advance.
- `rd_valid` drops the cycle after the `rd_last` transfer. A new CAPTURE write is accepted the same cycle.

## Configuration
- `FRAME_CAPTURE_BINARIZE_EN`
  - **Defined:** `rd_pixel` = (stored >= `THRESHOLD`) ? 8'hFF : 8'h00, applied on the readout path only. Stored data and timing are unchanged.
  - **Undefined:** `rd_pixel` is the raw stored pixel and `THRESHOLD` is unused.

## Test plan
- **Full frame:** reset, then 76800 consecutive `valid_in` pixels with value (i mod 256). Required: `frame_done`=1, `short_frame`=0, `capture_count`=76800.
- **Back-pressure readout:** `rd_start` with `rd_ready` toggling 1,0,0,1. Required: 76800 transfers matching (i mod 256) in order, `rd_last` only on index 76799, and data held during stalls.
- **Short frame:** 1000 pixels, then idle. Required: `frame_done` rises exactly 960 idle cycles after the last pixel plus 1 cycle, with `short_frame`=1 and `capture_count`=1000. Readout yields 1000 pixels.
- **Overflow:** pixels in FULL and in READOUT. Required: `overflow`=1 and stays 1 until reset. Buffer contents and `capture_count` are unchanged.
- **Reset mid-readout:** `rst`=0 after 500 transfers. Required: all outputs 0 the next cycle. A fresh 76800-pixel capture and readout then completes correctly.
- **Binarize, with `FRAME_CAPTURE_BINARIZE_EN` and `THRESHOLD`=128:** stored 127, 128 and 255 read out as 00, FF and FF.
